// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, queue
// geometry, queue entry layout and the default reset vector.
package fetch_defs;

    typedef enum logic {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } fetch_state_e;

    localparam int          QUEUE_DEPTH      = 2;
    localparam int          COUNT_W          = $clog2(QUEUE_DEPTH + 1);
    localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
    localparam logic [31:0] NOP_INSTR        = 32'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decode-side
// delivery, stall and redirect signals.
interface instr_fetch_if;

    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_hit;
    logic [31:0] mem_q;
    logic        stall;
    logic        flush;
    logic [31:0] jump_addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    modport master (
        output mem_addr, mem_req, instr, instr_pc, instr_valid,
        input  mem_hit, mem_q, stall, flush, jump_addr
    );

    modport slave (
        input  mem_addr, mem_req, instr, instr_pc, instr_valid,
        output mem_hit, mem_q, stall, flush, jump_addr
    );

endinterface

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instr} pairs; entry 0 is always the head, so a pop
// shifts the younger entry down and a simultaneous push lands behind it.
module fetch_queue
    import fetch_defs::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  fetch_entry_t       data_i,
    output logic [COUNT_W-1:0] count_o,
    output logic               valid_o,
    output fetch_entry_t       head_o
);

    fetch_entry_t       entry_q [QUEUE_DEPTH];
    fetch_entry_t       entry_d [QUEUE_DEPTH];
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic [COUNT_W-1:0] wr_slot;
    logic               do_push;
    logic               do_pop;

    assign do_pop  = pop_i && !clear_i && (count_q != '0);
    assign do_push = push_i && !clear_i && (do_pop || (count_q != COUNT_W'(QUEUE_DEPTH)));
    // A concurrent pop frees one slot below the current fill level.
    assign wr_slot = do_pop ? (count_q - 1'b1) : count_q;

    genvar gi;
    for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
        if (gi < QUEUE_DEPTH - 1) begin : g_shift
            assign entry_d[gi] = (do_push && (wr_slot == COUNT_W'(gi))) ? data_i :
                                 do_pop ? entry_q[gi + 1] : entry_q[gi];
        end else begin : g_tail
            assign entry_d[gi] = (do_push && (wr_slot == COUNT_W'(gi))) ? data_i : entry_q[gi];
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign head_o  = entry_q[0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request feeding a 2-entry
// prefetch queue, with redirect that can orphan an in-flight request.
module instr_fetch
    import fetch_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master fetch_if
);

    fetch_state_e       state_q;
    logic [31:0]        pc_q;
    logic [31:0]        hold_addr_q;
    logic [COUNT_W-1:0] q_count;
    logic               q_valid;
    fetch_entry_t       q_head;
    logic               req_int;
    logic               hit_taken;
    logic               q_push;
    logic               q_pop;
    fetch_entry_t       push_data;

    // Stop requesting once the queue cannot take another word; while
    // discarding, the orphaned request must still be seen through.
    assign req_int   = (state_q == ST_DISCARD) || (q_count < COUNT_W'(QUEUE_DEPTH));
    assign hit_taken = fetch_if.mem_hit && req_int;
    assign q_pop     = q_valid && !fetch_if.stall && !fetch_if.flush;
    assign q_push    = (state_q == ST_FETCH) && hit_taken && !fetch_if.flush;
    assign push_data = '{pc: pc_q, instr: fetch_if.mem_q};

    fetch_queue u_queue (
        .clk     (clk),
        .reset   (reset),
        .clear_i (fetch_if.flush),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .data_i  (push_data),
        .count_o (q_count),
        .valid_o (q_valid),
        .head_o  (q_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            hold_addr_q <= 32'd0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (fetch_if.flush) begin
                        pc_q <= align_word(fetch_if.jump_addr);
                        // The memory still owes us the old word; keep its address stable.
                        if (req_int && !fetch_if.mem_hit) begin
                            state_q     <= ST_DISCARD;
                            hold_addr_q <= pc_q;
                        end
                    end else if (q_push) begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                ST_DISCARD: begin
                    if (fetch_if.flush) begin
                        pc_q <= align_word(fetch_if.jump_addr);
                    end
                    if (fetch_if.mem_hit) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign fetch_if.mem_req     = req_int && !reset;
    assign fetch_if.mem_addr    = (state_q == ST_DISCARD) ? hold_addr_q : pc_q;
    assign fetch_if.instr_valid = q_valid;
    assign fetch_if.instr       = q_valid ? q_head.instr : NOP_INSTR;
    assign fetch_if.instr_pc    = q_valid ? q_head.pc : 32'd0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_instr_fetch;

    localparam int LAT_M1 = 2;  // 3-cycle memory: hit in the third request cycle

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int unsigned wait0 = 0;

    always #5 clk = ~clk;

    instr_fetch_if bus0 ();
    instr_fetch_if bus1 ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .fetch_if (bus0)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .fetch_if (bus1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    // Memory responders
    assign bus0.mem_hit = bus0.mem_req && (wait0 >= LAT_M1);
    assign bus0.mem_q   = bus0.mem_hit ? mem_word(bus0.mem_addr) : 32'h0;
    assign bus1.mem_hit = bus1.mem_req;
    assign bus1.mem_q   = bus1.mem_hit ? mem_word(bus1.mem_addr) : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset || bus0.mem_hit || !bus0.mem_req) wait0 <= 0;
        else wait0 <= wait0 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model of dut0
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_disc = 1'b0;
    logic [31:0] m_disc_addr = 32'h0;
    bit          m_ready = 1'b0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_pc = 32'h0;
            m_disc = 1'b0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            bit req, hit, pop;
            req = m_disc || (mq.size() < 2);
            hit = bus0.mem_hit && req;
            pop = (mq.size() > 0) && !bus0.stall && !bus0.flush;
            if (bus0.flush) begin
                mq.delete();
                if (m_disc) begin
                    if (hit) m_disc = 1'b0;
                end else if (req && !hit) begin
                    m_disc = 1'b1;
                    m_disc_addr = m_pc;
                end
                m_pc = bus0.jump_addr & 32'hFFFF_FFFC;
            end else if (m_disc) begin
                if (hit) m_disc = 1'b0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (hit) begin
                    mq.push_back('{pc: m_pc, instr: bus0.mem_q});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Every-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("rst_instr_valid", 32'(bus0.instr_valid), 32'd0);
            check("rst_instr", bus0.instr, 32'd0);
            check("rst_instr_pc", bus0.instr_pc, 32'd0);
            check("rst_mem_req", 32'(bus0.mem_req), 32'd0);
        end else if (m_ready) begin
            bit ev;
            ev = mq.size() > 0;
            check("instr_valid", 32'(bus0.instr_valid), 32'(ev));
            check("instr", bus0.instr, ev ? mq[0].instr : 32'd0);
            check("instr_pc", bus0.instr_pc, ev ? mq[0].pc : 32'd0);
            check("mem_req", 32'(bus0.mem_req), 32'(m_disc || (mq.size() < 2)));
            check("mem_addr", bus0.mem_addr, m_disc ? m_disc_addr : m_pc);
        end
    end

    // Delivery logs
    logic [31:0] del_pc[$];
    logic [31:0] del_in[$];
    int          del_cyc[$];
    logic [31:0] d1_pc[$];
    logic [31:0] d1_in[$];
    int          d1_cyc[$];

    initial forever begin
        @(posedge clk);
        if (!reset && bus0.instr_valid && !bus0.stall && !bus0.flush) begin
            del_pc.push_back(bus0.instr_pc);
            del_in.push_back(bus0.instr);
            del_cyc.push_back(cyc);
        end
        if (!reset && bus1.instr_valid && (d1_pc.size() < 4)) begin
            d1_pc.push_back(bus1.instr_pc);
            d1_in.push_back(bus1.instr);
            d1_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        del_pc.delete();
        del_in.delete();
        del_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rel_mem_req", 32'(bus0.mem_req), 32'd1);
        check("rel_mem_addr", bus0.mem_addr, 32'h0);
        clear_logs();
    endtask

    task automatic check_deliveries(input string name, input logic [31:0] pc0, input int n);
        check({name, "_count_ok"}, 32'(del_pc.size() >= n), 32'd1);
        if (del_pc.size() >= n) begin
            for (int i = 0; i < n; i++) begin
                check({name, "_pc"}, del_pc[i], pc0 + 32'(4 * i));
                check({name, "_instr"}, del_in[i], mem_word(pc0 + 32'(4 * i)));
            end
        end
    endtask

    initial begin
        bit found;
        bus0.stall = 1'b0; bus0.flush = 1'b0; bus0.jump_addr = 32'h0;
        bus1.stall = 1'b0; bus1.flush = 1'b0; bus1.jump_addr = 32'h0;

        // Reset and in-order streaming at 3-cycle latency
        do_reset();
        repeat (16) tick();
        check_deliveries("a_seq", 32'h0, 4);
        if (del_cyc.size() >= 4) begin
            for (int i = 1; i < 4; i++) check("a_gap", 32'(del_cyc[i] - del_cyc[i-1]), 32'd3);
        end

        // Zero-wait memory from a high reset vector: wrap and one per cycle
        check("w_count_ok", 32'(d1_pc.size() == 4), 32'd1);
        if (d1_pc.size() == 4) begin
            check("w_pc0", d1_pc[0], 32'hFFFF_FFF8);
            check("w_pc1", d1_pc[1], 32'hFFFF_FFFC);
            check("w_pc2", d1_pc[2], 32'h0000_0000);
            check("w_pc3", d1_pc[3], 32'h0000_0004);
            check("w_instr2", d1_in[2], 32'hA5A5_0F0F);
            for (int i = 1; i < 4; i++) check("w_gap", 32'(d1_cyc[i] - d1_cyc[i-1]), 32'd1);
        end

        // Long stall fills the queue and halts requests
        bus0.stall = 1'b1;
        do_reset();
        repeat (10) begin
            tick();
            if (bus0.instr_valid) check("b_head_pc", bus0.instr_pc, 32'h0);
        end
        check("b_valid", 32'(bus0.instr_valid), 32'd1);
        check("b_mem_req", 32'(bus0.mem_req), 32'd0);
        bus0.stall = 1'b0;
        clear_logs();
        repeat (12) tick();
        check_deliveries("b_resume", 32'h0, 3);

        // Redirect while the request to 8 is in flight
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus0.mem_req && bus0.mem_addr == 32'h8) found = 1'b1;
        end
        check("c_found_req8", 32'(found), 32'd1);
        bus0.flush = 1'b1; bus0.jump_addr = 32'h0000_0103;
        tick();
        bus0.flush = 1'b0;
        clear_logs();
        check("c_hold_addr", bus0.mem_addr, 32'h8);
        check("c_hold_req", 32'(bus0.mem_req), 32'd1);
        check("c_empty", 32'(bus0.instr_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus0.mem_addr != 32'h8) found = 1'b1;
        end
        check("c_new_addr", bus0.mem_addr, 32'h100);
        repeat (10) tick();
        check_deliveries("c_after", 32'h100, 2);

        // Redirect coincident with a hit
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus0.mem_hit) found = 1'b1;
        end
        check("d_found_hit", 32'(found), 32'd1);
        bus0.flush = 1'b1; bus0.jump_addr = 32'h0000_02A2;
        tick();
        bus0.flush = 1'b0;
        clear_logs();
        check("d_empty", 32'(bus0.instr_valid), 32'd0);
        check("d_addr", bus0.mem_addr, 32'h2A0);
        check("d_req", 32'(bus0.mem_req), 32'd1);
        repeat (10) tick();
        check_deliveries("d_after", 32'h2A0, 2);

        // Redirect with no request outstanding, then double redirect while discarding
        bus0.stall = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (!bus0.mem_req) found = 1'b1;
        end
        check("e_found_idle", 32'(found), 32'd1);
        bus0.flush = 1'b1; bus0.jump_addr = 32'h40;
        tick();
        bus0.stall = 1'b0;
        check("e_addr", bus0.mem_addr, 32'h40);
        check("e_req", 32'(bus0.mem_req), 32'd1);
        check("e_empty", 32'(bus0.instr_valid), 32'd0);
        bus0.jump_addr = 32'h300;
        tick();
        bus0.jump_addr = 32'h404;
        check("e_disc_addr1", bus0.mem_addr, 32'h40);
        tick();
        bus0.flush = 1'b0;
        check("e_disc_addr2", bus0.mem_addr, 32'h40);
        tick();
        check("e_final_addr", bus0.mem_addr, 32'h404);
        clear_logs();
        repeat (8) tick();
        check_deliveries("e_after", 32'h404, 2);

        // Asynchronous reset with one entry queued and a request in flight
        bus0.stall = 1'b1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus0.instr_valid && bus0.mem_req) found = 1'b1;
        end
        check("f_found", 32'(found), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("f_async_valid", 32'(bus0.instr_valid), 32'd0);
        check("f_async_pc", bus0.instr_pc, 32'd0);
        check("f_async_req", 32'(bus0.mem_req), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        bus0.stall = 1'b0;
        #1;
        check("f_rel_addr", bus0.mem_addr, 32'h0);
        check("f_rel_req", 32'(bus0.mem_req), 32'd1);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
